// File: rtl/ev_pred_pkg.sv
// Shared types, encodings and the saturating-count helper for the MicroEV20
// branch predictor.
package ev_pred_pkg;

    localparam int unsigned CNT_W  = 2;
    localparam int unsigned STAT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        PT_NONE = 2'b00,
        PT_JZE  = 2'b01,
        PT_JNE  = 2'b10,
        PT_JCY  = 2'b11
    } pred_type_e;

    localparam cnt_t CNT_INIT = 2'b01;
    localparam cnt_t CNT_MAX  = 2'b11;
    localparam cnt_t CNT_MIN  = 2'b00;

    // Next value of a 2-bit saturating counter moved one step up or down.
    function automatic cnt_t sat_next(input cnt_t cnt, input logic up);
        cnt_t nxt;
        nxt = cnt;
        if (up) begin
            if (cnt != CNT_MAX) nxt = cnt + cnt_t'(1);
        end else begin
            if (cnt != CNT_MIN) nxt = cnt - cnt_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch / checker bus of the branch predictor.
// Optional statistics outputs are present only when BP_STATS_EN is defined.
interface branch_predictor_if
#(
    parameter int unsigned ADDR_W = 8
);
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_is_branch;
    logic [1:0]        fetch_pred_type;
    logic              stall;
    logic              checked;
    logic              correct_pred;
    logic              incorrect_pred;
    logic              pred_taken;
    logic              last_pred;
    logic [1:0]        pred_type;
    logic              flush;
`ifdef BP_STATS_EN
    logic [15:0]       stat_checked;
    logic [15:0]       stat_mispred;
`endif

    modport master (
        output fetch_valid, fetch_addr, fetch_is_branch, fetch_pred_type,
        output stall, checked, correct_pred, incorrect_pred,
`ifdef BP_STATS_EN
        input  stat_checked, stat_mispred,
`endif
        input  pred_taken, last_pred, pred_type, flush
    );

    modport slave (
        input  fetch_valid, fetch_addr, fetch_is_branch, fetch_pred_type,
        input  stall, checked, correct_pred, incorrect_pred,
`ifdef BP_STATS_EN
        output stat_checked, stat_mispred,
`endif
        output pred_taken, last_pred, pred_type, flush
    );

endinterface

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, one per prediction table entry.
module sat_counter2
    import ev_pred_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic up_i,
    output cnt_t cnt_o
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    // Step the counter when enabled, saturating at both ends.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = sat_next(cnt_q, up_i);
    end

    // Counter register, synchronous reset to weakly-not-taken.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= CNT_INIT;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// MicroEV20 conditional-jump predictor: counter table, shadow pipeline that
// carries each guess to execute, training and mispredict flush.
// Optional feature macro: BP_STATS_EN adds saturating training/flush counters.
module branch_predictor
    import ev_pred_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned PIPE_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bus
);

    localparam int unsigned NUM_CNT = 2 ** IDX_W;
    localparam int unsigned LAST    = PIPE_DEPTH - 1;

    typedef struct packed {
        logic             valid;
        logic             trained;
        logic [IDX_W-1:0] idx;
        logic [1:0]       ptype;
        logic             pred;
    } shadow_t;

    shadow_t          sh_q [PIPE_DEPTH];
    shadow_t          sh_d [PIPE_DEPTH];
    shadow_t          load_c;
    cnt_t             cnt [NUM_CNT];
    cnt_t             rd_cnt;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] train_idx;
    logic             train_c;
    logic             mispred_c;
    logic             pred_taken_c;
    logic             flush_q;
    logic             unused_addr_hi;

    assign fetch_idx      = bus.fetch_addr[IDX_W-1:0];
    assign unused_addr_hi = ^bus.fetch_addr[ADDR_W-1:IDX_W];
    assign train_idx      = sh_q[LAST].idx;

    // A verdict trains only a valid entry that has not already trained.
    assign train_c   = bus.checked & sh_q[LAST].valid & ~sh_q[LAST].trained;
    assign mispred_c = train_c & bus.incorrect_pred;

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        sat_counter2 u_cnt (
            .clk   (clk),
            .rst   (rst),
            .en_i  (train_c && (train_idx == IDX_W'(g))),
            .up_i  (bus.correct_pred),
            .cnt_o (cnt[g])
        );
    end

    // Table read with write-first bypass from the entry being trained.
    always_comb begin
        rd_cnt = cnt[fetch_idx];
        if (train_c && (train_idx == fetch_idx)) rd_cnt = sat_next(rd_cnt, bus.correct_pred);
        pred_taken_c = bus.fetch_is_branch & rd_cnt[CNT_W-1];
    end

    // Shadow pipeline next state: shift/hold, trained marking, squash on mispredict.
    always_comb begin
        load_c         = '0;
        load_c.valid   = bus.fetch_valid & bus.fetch_is_branch
                         & (bus.fetch_pred_type != PT_NONE) & ~flush_q;
        load_c.trained = 1'b0;
        load_c.idx     = fetch_idx;
        load_c.ptype   = bus.fetch_pred_type;
        load_c.pred    = pred_taken_c;
        sh_d = sh_q;
        if (!bus.stall) begin
            for (int i = int'(PIPE_DEPTH) - 1; i > 0; i--) sh_d[i] = sh_q[i-1];
            sh_d[0] = load_c;
        end else if (train_c) begin
            sh_d[LAST].trained = 1'b1;
        end
        if (mispred_c) begin
            for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
                if (!bus.stall || (i != int'(LAST))) sh_d[i].valid = 1'b0;
            end
        end
    end

    // Shadow pipeline and flush registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(PIPE_DEPTH); i++) sh_q[i] <= '0;
            flush_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            flush_q <= mispred_c;
        end
    end

    assign bus.pred_taken = pred_taken_c;
    assign bus.last_pred  = sh_q[LAST].valid & sh_q[LAST].pred;
    assign bus.pred_type  = sh_q[LAST].valid ? sh_q[LAST].ptype : PT_NONE;
    assign bus.flush      = flush_q;

`ifdef BP_STATS_EN
    logic [STAT_W-1:0] stat_checked_q;
    logic [STAT_W-1:0] stat_mispred_q;

    // Saturating event counters for training and flush events.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_checked_q <= '0;
            stat_mispred_q <= '0;
        end else begin
            if (train_c && (stat_checked_q != '1))   stat_checked_q <= stat_checked_q + STAT_W'(1);
            if (mispred_c && (stat_mispred_q != '1)) stat_mispred_q <= stat_mispred_q + STAT_W'(1);
        end
    end

    assign bus.stat_checked = stat_checked_q;
    assign bus.stat_mispred = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_branch_predictor;
    import ev_pred_pkg::*;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned IDX_W  = 4;
    localparam int          DEPTH  = 2;
    localparam int          NUM    = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bit         fv, br, st, ck, cp, ip;
    logic [7:0] addr;
    logic [1:0] ty;

    branch_predictor_if #(.ADDR_W(ADDR_W)) bus ();

    branch_predictor #(
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .PIPE_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.fetch_valid     = fv;
    assign bus.fetch_addr      = addr;
    assign bus.fetch_is_branch = br;
    assign bus.fetch_pred_type = ty;
    assign bus.stall           = st;
    assign bus.checked         = ck;
    assign bus.correct_pred    = cp;
    assign bus.incorrect_pred  = ip;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: counter values and in-flight guesses, oldest at DEPTH-1.
    int cnt_m [NUM];
    bit v_m   [DEPTH];
    bit tr_m  [DEPTH];
    int ix_m  [DEPTH];
    int ty_m  [DEPTH];
    bit pr_m  [DEPTH];
    bit flush_m;
    int stc_m;
    int stm_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int c, input bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic bit verdict_applies();
        return ck && v_m[DEPTH-1] && !tr_m[DEPTH-1];
    endfunction

    function automatic bit exp_pred();
        int c;
        int fi;
        fi = int'(addr) % NUM;
        c  = cnt_m[fi];
        if (verdict_applies() && (ix_m[DEPTH-1] == fi)) c = sat(c, cp);
        return br && (c >= 2);
    endfunction

    task automatic model_edge(input bit pt);
        bit train;
        bit mis;
        int li;
        li = DEPTH - 1;
        if (rst) begin
            for (int i = 0; i < NUM; i++) cnt_m[i] = 1;
            for (int i = 0; i < DEPTH; i++) begin
                v_m[i]  = 1'b0;
                tr_m[i] = 1'b0;
            end
            flush_m = 1'b0;
            stc_m   = 0;
            stm_m   = 0;
        end else begin
            train = verdict_applies();
            mis   = train && ip;
            if (train) cnt_m[ix_m[li]] = sat(cnt_m[ix_m[li]], cp);
            if (!st) begin
                for (int i = li; i > 0; i--) begin
                    v_m[i]  = v_m[i-1];
                    tr_m[i] = tr_m[i-1];
                    ix_m[i] = ix_m[i-1];
                    ty_m[i] = ty_m[i-1];
                    pr_m[i] = pr_m[i-1];
                end
                v_m[0]  = fv && br && (ty != 2'b00) && !flush_m;
                tr_m[0] = 1'b0;
                ix_m[0] = int'(addr) % NUM;
                ty_m[0] = int'(ty);
                pr_m[0] = pt;
            end else if (train) begin
                tr_m[li] = 1'b1;
            end
            if (mis) begin
                for (int i = 0; i < DEPTH; i++) if (!st || i != li) v_m[i] = 1'b0;
            end
            flush_m = mis;
            if (train && stc_m < 65535) stc_m++;
            if (mis && stm_m < 65535) stm_m++;
        end
    endtask

    // One clock: check the fetch guess before the edge, the registered outputs after.
    task automatic tick(input string tag);
        bit pt;
        #1;
        pt = exp_pred();
        check({tag, "/pred_taken"}, 32'(bus.pred_taken), 32'(pt));
        @(posedge clk);
        model_edge(pt);
        #1;
        check({tag, "/last_pred"}, 32'(bus.last_pred), 32'(v_m[DEPTH-1] && pr_m[DEPTH-1]));
        check({tag, "/pred_type"}, 32'(bus.pred_type), v_m[DEPTH-1] ? 32'(ty_m[DEPTH-1]) : 32'd0);
        check({tag, "/flush"}, 32'(bus.flush), 32'(flush_m));
`ifdef BP_STATS_EN
        check({tag, "/stat_checked"}, 32'(bus.stat_checked), 32'(stc_m));
        check({tag, "/stat_mispred"}, 32'(bus.stat_mispred), 32'(stm_m));
`endif
    endtask

    task automatic peek_pt(input string tag, input bit exp);
        #1;
        check(tag, 32'(bus.pred_taken), 32'(exp));
    endtask

    task automatic drive(input bit f_v, input logic [7:0] a, input bit b, input logic [1:0] t,
                         input bit s, input bit c, input bit p, input bit i);
        fv = f_v; addr = a; br = b; ty = t; st = s; ck = c; cp = p; ip = i;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, PT_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        tick("rst0");
        tick("rst1");
        check("rst/flush", 32'(bus.flush), 32'd0);
        rst = 1'b0;

        // Fetch 0x13 as JZE: weakly not taken, type visible two cycles later.
        drive(1'b1, 8'h13, 1'b1, PT_JZE, 1'b0, 1'b0, 1'b0, 1'b0);
        peek_pt("s1/pred_weak", 1'b0);
        tick("s1_f");
        idle();
        tick("s1_w");
        check("s1/last_pred", 32'(bus.last_pred), 32'd0);
        check("s1/pred_type", 32'(bus.pred_type), 32'd1);
        tick("s1_d");

        // Three taken verdicts at idx 3 saturate the counter.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h03, 1'b1, PT_JZE, 1'b0, 1'b1, 1'b1, 1'b0);
            tick("s2_f");
        end
        drive(1'b0, 8'h00, 1'b0, PT_NONE, 1'b0, 1'b1, 1'b1, 1'b0);
        tick("s2_v0");
        tick("s2_v1");
        drive(1'b1, 8'h03, 1'b1, PT_JZE, 1'b0, 1'b0, 1'b0, 1'b0);
        peek_pt("s2/pred_sat", 1'b1);
        tick("s2_p");
        idle();
        tick("s2_d0");
        tick("s2_d1");

        // Mispredict: one-cycle flush, younger JCY squashed, flush-cycle fetch dropped.
        drive(1'b1, 8'h03, 1'b1, PT_JZE, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("s3_a");
        drive(1'b1, 8'h07, 1'b1, PT_JCY, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("s3_b");
        drive(1'b0, 8'h00, 1'b0, PT_NONE, 1'b0, 1'b1, 1'b0, 1'b1);
        tick("s3_v");
        check("s3/flush_set", 32'(bus.flush), 32'd1);
        check("s3/young_squashed", 32'(bus.pred_type), 32'd0);
        drive(1'b1, 8'h08, 1'b1, PT_JZE, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("s3_fc");
        check("s3/flush_clear", 32'(bus.flush), 32'd0);
        idle();
        tick("s3_d");
        check("s3/flush_load_dropped", 32'(bus.pred_type), 32'd0);

        // Held verdict under stall: one update, one flush, stable outputs.
        drive(1'b1, 8'h04, 1'b1, PT_JNE, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("s4_a");
        drive(1'b1, 8'h09, 1'b1, PT_JZE, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("s4_b");
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 8'h00, 1'b0, PT_NONE, 1'b1, 1'b1, 1'b1, 1'b1);
            tick("s4_st");
            check("s4/last_pred_stable", 32'(bus.last_pred), 32'd0);
            check("s4/pred_type_stable", 32'(bus.pred_type), 32'd2);
            check("s4/flush_once", 32'(bus.flush), (k == 0) ? 32'd1 : 32'd0);
        end
        idle();
        tick("s4_rel");
        drive(1'b1, 8'h04, 1'b1, PT_JNE, 1'b0, 1'b0, 1'b0, 1'b0);
        peek_pt("s4/one_update", 1'b1);
        tick("s4_c");
        idle();
        tick("s4_c1");
        drive(1'b0, 8'h00, 1'b0, PT_NONE, 1'b0, 1'b1, 1'b0, 1'b0);
        tick("s4_dec");
        drive(1'b1, 8'h04, 1'b1, PT_JNE, 1'b0, 1'b0, 1'b0, 1'b0);
        peek_pt("s4/back_to_weak", 1'b0);
        tick("s4_e");
        idle();
        tick("s4_d");

        // Write-first bypass: idx 5 10->11 and idx 6 01->10 on a same-cycle fetch.
        drive(1'b1, 8'h05, 1'b1, PT_JZE, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("s5_a");
        idle();
        tick("s5_a1");
        drive(1'b1, 8'h05, 1'b1, PT_JZE, 1'b0, 1'b1, 1'b1, 1'b0);
        tick("s5_tr");
        idle();
        tick("s5_b1");
        drive(1'b1, 8'h25, 1'b1, PT_JZE, 1'b0, 1'b1, 1'b1, 1'b0);
        peek_pt("s5/bypass_sat", 1'b1);
        tick("s5_byp");
        drive(1'b1, 8'h06, 1'b1, PT_JNE, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("s5_c");
        idle();
        tick("s5_c1");
        drive(1'b1, 8'h16, 1'b1, PT_JZE, 1'b0, 1'b1, 1'b1, 1'b0);
        peek_pt("s5/bypass_flip", 1'b1);
        tick("s5_byp2");
        idle();
        tick("s5_d0");
        tick("s5_d1");

        // Reset mid-stream overrides a pending mispredict verdict.
        drive(1'b1, 8'h03, 1'b1, PT_JZE, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("s6_a");
        drive(1'b1, 8'h0A, 1'b1, PT_JNE, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("s6_b");
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, PT_NONE, 1'b1, 1'b1, 1'b0, 1'b1);
        tick("s6_rst");
        check("s6/flush", 32'(bus.flush), 32'd0);
        check("s6/last_pred", 32'(bus.last_pred), 32'd0);
        check("s6/pred_type", 32'(bus.pred_type), 32'd0);
`ifdef BP_STATS_EN
        check("s6/stat_mispred", 32'(bus.stat_mispred), 32'd0);
`endif
        rst = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            drive(1'b1, 8'(i), 1'b1, PT_JZE, 1'b0, 1'b0, 1'b0, 1'b0);
            peek_pt("s6/cnt_init", 1'b0);
            tick("s6_scan");
        end

        // Randomized traffic over a reduced address set to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(63) == 0);
            drive($urandom_range(3) != 0, 8'($urandom & 32'hF3), 1'($urandom_range(1)),
                  2'($urandom_range(3)), $urandom_range(3) == 0, 1'($urandom_range(1)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
            tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Front-end predictor for the MicroEV20 microsequencer conditional jumps: JZE, JNE and JCY.
- At fetch it gives a taken/not-taken guess from a table of 2-bit saturating counters indexed by the microaddress.
- It carries each guess (last_pred, pred_type) down an aligned shadow pipeline so the guess reaches the prediction checker at execute.
- It takes the checker's verdict back to train the table and raise a one-cycle flush on a mispredict.

Parameters:
- ADDR_W, 8: microprogram address width.
- IDX_W, 4: table index width; 2**IDX_W counters, indexed by fetch_addr[IDX_W-1:0].
- PIPE_DEPTH, 2: number of stages from fetch to execute; legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_valid  in  1  a microinstruction is being fetched this cycle.
- fetch_addr  in  ADDR_W  microaddress being fetched.
- fetch_is_branch  in  1  the fetched MIR is a conditional jump.
- fetch_pred_type  in  2  01 = JZE, 10 = JNE, 11 = JCY, 00 = none.
- stall  in  1  pipeline hold; the shadow pipeline freezes.
- checked  in  1  from the checker: the execute-stage MIR carried a prediction.
- correct_pred  in  1  from the checker: the branch outcome that should have been predicted (1 = taken).
- incorrect_pred  in  1  from the checker: the prediction was wrong.
- pred_taken  out  1  combinational guess to the fetch mux; 0 when fetch_is_branch = 0.
- last_pred  out  1  prediction of the execute-stage MIR, to the checker.
- pred_type  out  2  type of the execute-stage MIR, to the checker.
- flush  out  1  registered one-cycle pulse that squashes younger stages and redirects fetch.

Behaviour:
- Table: 2**IDX_W counters, 2 bits each.
  - MSB gives pred_taken.
  - Increment saturates at 11; decrement saturates at 00.
- Reset:
  - All counters are set to 01 (weakly not taken).
  - All shadow entries are made invalid.
  - last_pred = 0, pred_type = 00, flush = 0.
  - Reset asserted mid-operation overrides stall, checker inputs and any pending flush in the same cycle.
- Shadow pipeline:
  - PIPE_DEPTH entries, each {valid, idx, type, pred}.
  - Stage 0 is loaded with {fetch_valid & fetch_is_branch, idx, fetch_pred_type, pred_taken}.
  - Entries shift each cycle when stall = 0 and hold when stall = 1.
  - last_pred / pred_type are driven from the last entry. When that entry is invalid they are 0 / 00.
- Training: when checked = 1 and the last entry is valid, counter[entry.idx] is updated in that cycle.
  - correct_pred = 1 increments the counter.
  - correct_pred = 0 decrements the counter.
  - Training happens even when stall = 1, but at most once per entry; a per-entry trained bit blocks repeat updates while stalled.
- Mispredict:
  - checked & incorrect_pred & a valid, untrained last entry sets flush = 1 on the next cycle, for exactly one cycle.
  - On the same edge every younger shadow entry is invalidated.
  - The fetch-side load in the flush cycle is also discarded.
- Read/write collision: when a fetch index equals the index being trained in the same cycle, pred_taken uses the updated counter (write-first bypass).
- checked = 1 with the last entry invalid: the input is ignored. No training and no flush.
- fetch_pred_type = 00 with fetch_is_branch = 1: the entry is loaded as invalid.
- Latency: from fetch to last_pred is PIPE_DEPTH unstalled cycles; from verdict to flush is 1 cycle.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, two 16-bit saturating output counters are added.
  - stat_checked counts training events.
  - stat_mispred counts flush events.
  - Both clear on rst and stop counting at 0xFFFF.
- When undefined, these ports and registers do not exist, and all other behaviour is identical.

Decomposition:
- Shared package ev_pred_pkg holds:
  - pred_type encodings PT_NONE = 00, PT_JZE = 01, PT_JNE = 10, PT_JCY = 11;
  - counter reset value CNT_INIT = 01;
  - counter width.
- One sub-module, sat_counter2: a 2-bit saturating up/down counter with a synchronous reset to CNT_INIT, instantiated per table entry.
- Shadow pipeline and flush logic stay in branch_predictor.

Test Plan:
1. Reset, then fetch addr 0x13 as JZE → pred_taken = 0; after 2 cycles last_pred = 0, pred_type = 01.
2. Three checked verdicts with correct_pred = 1 at idx 3 → counter 01→10→11→11 (saturates); pred_taken = 1 for addr 0x03.
3. checked = 1, incorrect_pred = 1 on a valid entry → flush = 1 for exactly the next cycle; the younger JCY entry is invalid, so pred_type = 00 afterwards.
4. stall = 1 for 3 cycles while checked = 1 is held → exactly one counter update and one flush; last_pred is stable throughout.
5. Same-cycle training of idx 5 (10→11 via correct_pred = 1) and a fetch of addr 0x25 → pred_taken reflects 11 (bypass) and equals 1.
6. Assert rst mid-stream with checked = 1, incorrect_pred = 1 → flush = 0 next cycle, all counters 01, last_pred = 0; with BP_STATS_EN, stat_mispred = 0.
